seg7_bus_decoder: RTL and testbench

//  Receive side of the multiplexed seven-segment display bus. Samples the

---
 rtl/seg7_bus_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_seg7_bus_decoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_bus_decoder.sv
// Receive side of the multiplexed seven-segment bus: synchronises segments and anodes,
// waits for a stable pattern, then decodes it back to hex and stores it per digit.
module seg7_bus_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    clear_err,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   pattern_err,
  output logic                    multi_an_err,
  output logic                    frame_done
);

  localparam int WORD_W = NUM_DIGITS + 7;
  localparam int CNT_W  = $clog2(STABLE_CYCLES);

  typedef enum logic {
    ST_SETTLE,
    ST_HELD
  } state_t;

  typedef enum logic [1:0] {
    SEG_HEX,
    SEG_BLANK,
    SEG_BAD
  } seg_kind_t;

  typedef struct packed {
    seg_kind_t  kind;
    logic [3:0] value;
  } seg_dec_t;

  function automatic seg_dec_t decode_seg(input logic [6:0] seg);
    seg_dec_t d;
    d.kind  = SEG_HEX;
    d.value = 4'h0;
    case (seg)
      7'h40: d.value = 4'h0;
      7'h79: d.value = 4'h1;
      7'h24: d.value = 4'h2;
      7'h30: d.value = 4'h3;
      7'h19: d.value = 4'h4;
      7'h12: d.value = 4'h5;
      7'h02: d.value = 4'h6;
      7'h78: d.value = 4'h7;
      7'h00: d.value = 4'h8;
      7'h18: d.value = 4'h9;
      7'h08: d.value = 4'hA;
      7'h03: d.value = 4'hB;
      7'h27: d.value = 4'hC;
      7'h21: d.value = 4'hD;
      7'h06: d.value = 4'hE;
      7'h0E: d.value = 4'hF;
      7'h3F, 7'h7F: d.kind = SEG_BLANK;
      default: d.kind = SEG_BAD;
    endcase
    return d;
  endfunction

  // Synchronisers and the stable-word tracker
  logic [6:0]              r_seg_meta, r_seg_sync;
  logic [NUM_DIGITS-1:0]   r_an_meta, r_an_sync;
  logic [WORD_W-1:0]       r_word_prev;
  logic [WORD_W-1:0]       w_word;
  logic                    w_changed;

  state_t                  r_state, w_state_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next;
  logic                    w_eval;

  // Decode and capture datapath
  logic [NUM_DIGITS-1:0]   w_an_low;
  logic                    w_single, w_multi;
  seg_dec_t                w_dec;

  logic [4*NUM_DIGITS-1:0] r_digits, w_digits_next;
  logic [NUM_DIGITS-1:0]   r_valid, w_valid_next;
  logic [NUM_DIGITS-1:0]   r_perr, w_perr_next;
  logic                    r_merr, w_merr_next;
  logic [NUM_DIGITS-1:0]   r_mask, w_mask_next;
  logic                    r_frame, w_frame_next;

  // NOTE: every register is written with <= so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_meta  <= '0;
      r_seg_sync  <= '0;
      r_an_meta   <= '0;
      r_an_sync   <= '0;
      r_word_prev <= '0;
    end else begin
      r_seg_meta  <= seg_in;
      r_seg_sync  <= r_seg_meta;
      r_an_meta   <= an_in;
      r_an_sync   <= r_an_meta;
      r_word_prev <= w_word;
    end
  end

  assign w_word    = {r_an_sync, r_seg_sync};
  assign w_changed = (w_word != r_word_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SETTLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Evaluation fires on the edge where the count of identical samples reaches
  // STABLE_CYCLES-1, i.e. the STABLE_CYCLES-th consecutive copy of the word.
  // NOTE: defaults first in every always_comb so no path leaves a variable unassigned (no latches).
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_eval       = 1'b0;
    case (r_state)
      ST_SETTLE: begin
        if (w_changed) begin
          w_cnt_next = '0;
        end else if (r_cnt == CNT_W'(STABLE_CYCLES - 2)) begin
          w_eval       = 1'b1;
          w_state_next = ST_HELD;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (w_changed) begin
          w_state_next = ST_SETTLE;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = ST_SETTLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign w_an_low = ~r_an_sync;
  assign w_single = $onehot(w_an_low);
  assign w_multi  = !$onehot0(w_an_low);
  assign w_dec    = decode_seg(r_seg_sync);

  // A set event in the same cycle as clear_err overrides the clear.
  always_comb begin
    w_digits_next = r_digits;
    w_valid_next  = r_valid;
    w_perr_next   = clear_err ? '0 : r_perr;
    w_merr_next   = clear_err ? 1'b0 : r_merr;
    w_mask_next   = r_mask;
    w_frame_next  = 1'b0;
    if (w_eval) begin
      if (w_multi) begin
        w_merr_next = 1'b1;
      end else if (w_single) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (w_an_low[i]) begin
            case (w_dec.kind)
              SEG_HEX: begin
                w_digits_next[4*i +: 4] = w_dec.value;
                w_valid_next[i]         = 1'b1;
              end
              SEG_BLANK: w_valid_next[i] = 1'b0;
              default: begin
                w_valid_next[i] = 1'b0;
                w_perr_next[i]  = 1'b1;
              end
            endcase
          end
        end
        if (&(r_mask | w_an_low)) begin
          w_mask_next  = '0;
          w_frame_next = 1'b1;
        end else begin
          w_mask_next = r_mask | w_an_low;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= '0;
      r_valid  <= '0;
      r_perr   <= '0;
      r_merr   <= 1'b0;
      r_mask   <= '0;
      r_frame  <= 1'b0;
    end else begin
      r_digits <= w_digits_next;
      r_valid  <= w_valid_next;
      r_perr   <= w_perr_next;
      r_merr   <= w_merr_next;
      r_mask   <= w_mask_next;
      r_frame  <= w_frame_next;
    end
  end

  assign digits_out   = r_digits;
  assign digit_valid  = r_valid;
  assign pattern_err  = r_perr;
  assign multi_an_err = r_merr;
  assign frame_done   = r_frame;

endmodule

// File: tb/tb_seg7_bus_decoder.sv
// Directed bench for seg7_bus_decoder: latency, scanning, short dwells, errors,
// clear/set priority and reset in the middle of a frame.
module tb_seg7_bus_decoder;

  localparam int ND = 4;
  localparam int SC = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg_in;
  logic [ND-1:0] an_in;
  logic          clear_err;
  logic [4*ND-1:0] digits_out;
  logic [ND-1:0] digit_valid;
  logic [ND-1:0] pattern_err;
  logic          multi_an_err;
  logic          frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_bus_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_in       (seg_in),
    .an_in        (an_in),
    .clear_err    (clear_err),
    .digits_out   (digits_out),
    .digit_valid  (digit_valid),
    .pattern_err  (pattern_err),
    .multi_an_err (multi_an_err),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Holds one bus word for a number of cycles, counting frame_done pulses.
  task automatic dwell(input logic [ND-1:0] an, input logic [6:0] seg,
                       input int cycles, output int pulses);
    pulses = 0;
    an_in  = an;
    seg_in = seg;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (frame_done) pulses++;
    end
  endtask

  task automatic idle(input int cycles);
    int p;
    dwell(4'hF, 7'h7F, cycles, p);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; an_in = 4'hF; seg_in = 7'h7F; clear_err = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (digits_out !== 16'h0) begin n_bad++; $display("FAIL reset_digits: got %h want 0000", digits_out); end
    n_cmp++; if (digit_valid !== 4'h0) begin n_bad++; $display("FAIL reset_valid: got %b want 0000", digit_valid); end
    n_cmp++; if ({pattern_err, multi_an_err, frame_done} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000000", {pattern_err, multi_an_err, frame_done}); end
    rst_n = 1'b1;
    idle(12);
  endtask

  task automatic test_latency();
    an_in = 4'hE; seg_in = 7'h30;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == SC + 1) begin
        n_cmp++; if (digit_valid !== 4'b0000) begin n_bad++; $display("FAIL latency_early: valid %b want 0000 at clk %0d", digit_valid, k); end
      end
      if (k == SC + 2) begin
        n_cmp++; if (digit_valid !== 4'b0001) begin n_bad++; $display("FAIL latency_valid: valid %b want 0001 at clk %0d", digit_valid, k); end
        n_cmp++; if (digits_out[3:0] !== 4'h3) begin n_bad++; $display("FAIL latency_value: got %h want 3", digits_out[3:0]); end
      end
    end
  endtask

  task automatic test_scan();
    int p0, p1, p2, p3;
    dwell(4'hE, 7'h12, 16, p0);
    dwell(4'hD, 7'h08, 16, p1);
    dwell(4'hB, 7'h00, 16, p2);
    dwell(4'h7, 7'h0E, 16, p3);
    n_cmp++; if (digits_out !== 16'hF8A5) begin n_bad++; $display("FAIL scan_digits: got %h want F8A5", digits_out); end
    n_cmp++; if (digit_valid !== 4'hF) begin n_bad++; $display("FAIL scan_valid: got %b want 1111", digit_valid); end
    n_cmp++; if (p0 + p1 + p2 !== 0) begin n_bad++; $display("FAIL scan_early_frame: got %0d pulses want 0", p0 + p1 + p2); end
    n_cmp++; if (p3 !== 1) begin n_bad++; $display("FAIL scan_frame: got %0d pulses want 1", p3); end
    idle(8);
  endtask

  task automatic test_short_dwell();
    int p;
    dwell(4'hD, 7'h79, SC - 1, p);
    idle(16);
    n_cmp++; if (digits_out[7:4] !== 4'hA) begin n_bad++; $display("FAIL short_value: got %h want A", digits_out[7:4]); end
    n_cmp++; if (digit_valid !== 4'hF) begin n_bad++; $display("FAIL short_valid: got %b want 1111", digit_valid); end
    dwell(4'hD, 7'h79, SC, p);
    idle(16);
    n_cmp++; if (digits_out[7:4] !== 4'h1) begin n_bad++; $display("FAIL full_dwell_value: got %h want 1", digits_out[7:4]); end
  endtask

  task automatic test_pattern_err();
    int p;
    dwell(4'hB, 7'h55, 16, p);
    n_cmp++; if (pattern_err !== 4'b0100) begin n_bad++; $display("FAIL perr_set: got %b want 0100", pattern_err); end
    n_cmp++; if (digits_out[11:8] !== 4'h8) begin n_bad++; $display("FAIL perr_held: got %h want 8", digits_out[11:8]); end
    n_cmp++; if (digit_valid !== 4'b1011) begin n_bad++; $display("FAIL perr_valid: got %b want 1011", digit_valid); end
    pulse_clear();
    n_cmp++; if (pattern_err !== 4'b0000) begin n_bad++; $display("FAIL perr_clear: got %b want 0000", pattern_err); end
    idle(16);
    // clear_err coincides with the capture edge of the bad pattern
    an_in = 4'hB; seg_in = 7'h55;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      clear_err = (k == SC + 1);
    end
    n_cmp++; if (pattern_err !== 4'b0100) begin n_bad++; $display("FAIL perr_set_wins: got %b want 0100", pattern_err); end
    pulse_clear();
    idle(16);
  endtask

  task automatic test_multi_an();
    int p;
    dwell(4'hC, 7'h40, 16, p);
    n_cmp++; if (multi_an_err !== 1'b1) begin n_bad++; $display("FAIL multi_set: got %b want 1", multi_an_err); end
    n_cmp++; if (digits_out !== 16'hF815) begin n_bad++; $display("FAIL multi_digits: got %h want F815", digits_out); end
    n_cmp++; if (digit_valid !== 4'b1011) begin n_bad++; $display("FAIL multi_valid: got %b want 1011", digit_valid); end
    dwell(4'hE, 7'h3F, 16, p);
    n_cmp++; if (digit_valid !== 4'b1010) begin n_bad++; $display("FAIL dash_valid: got %b want 1010", digit_valid); end
    n_cmp++; if (pattern_err !== 4'b0000) begin n_bad++; $display("FAIL dash_err: got %b want 0000", pattern_err); end
    n_cmp++; if (digits_out[3:0] !== 4'h5) begin n_bad++; $display("FAIL dash_held: got %h want 5", digits_out[3:0]); end
    pulse_clear();
    n_cmp++; if (multi_an_err !== 1'b0) begin n_bad++; $display("FAIL multi_clear: got %b want 0", multi_an_err); end
    idle(8);
  endtask

  task automatic test_reset_mid_scan();
    int p0, p1, p2, p3;
    dwell(4'hE, 7'h12, 16, p0);
    dwell(4'hD, 7'h08, 16, p1);
    an_in = 4'hB; seg_in = 7'h00;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({digits_out, digit_valid, pattern_err, multi_an_err, frame_done} !== 26'b0) begin
      n_bad++; $display("FAIL midreset_outputs: got %h/%b want all zero", digits_out, digit_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dwell(4'h7, 7'h0E, 16, p0);
    dwell(4'hB, 7'h00, 16, p1);
    dwell(4'hD, 7'h08, 16, p2);
    dwell(4'hE, 7'h12, 16, p3);
    n_cmp++; if (p0 + p1 + p2 !== 0) begin n_bad++; $display("FAIL midreset_early_frame: got %0d pulses want 0", p0 + p1 + p2); end
    n_cmp++; if (p3 !== 1) begin n_bad++; $display("FAIL midreset_frame: got %0d pulses want 1", p3); end
    n_cmp++; if (digits_out !== 16'hF8A5) begin n_bad++; $display("FAIL midreset_digits: got %h want F8A5", digits_out); end
    n_cmp++; if (digit_valid !== 4'hF) begin n_bad++; $display("FAIL midreset_valid: got %b want 1111", digit_valid); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_scan();
    test_short_dwell();
    test_pattern_err();
    test_multi_an();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
